// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin AXI4-Stream packet arbiter.
package axis_arb_pkg;

    // Input-side sequencing: idle (arbitrating) or busy (forwarding one packet).
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

    // Width of each per-source packet counter.
    localparam int unsigned PKT_CNT_W = 16;

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the N upstream stream sources and the single downstream stream.
// The arbiter sits on the slave modport: it consumes the s_axis_* sources and drives m_axis_*.
// The master modport is the view of whatever surrounds the arbiter (sources and sink).
interface axis_rr_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned DEST_W = $clog2(NUM_SRC);

    logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]        s_axis_tvalid;
    logic [NUM_SRC-1:0]        s_axis_tlast;
    logic [NUM_SRC-1:0]        s_axis_tready;

    logic [DATA_W-1:0]         m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic [DEST_W-1:0]         m_axis_tdest;
    logic                      m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );

endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, scanning upward
// modulo NUM_SRC.
module axis_rr_pick #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] ptr,
    output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
    output logic                       gnt_any
);
    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    // Rotating priority scan starting at ptr; first hit wins.
    always_comb begin : p_pick
        int unsigned idx;
        logic [IDX_W-1:0] pos;
        idx     = 0;
        pos     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            pos = IDX_W'(idx);
            if (!gnt_any && req[pos]) begin
                gnt_any = 1'b1;
                gnt_idx = pos;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin N:1 AXI4-Stream packet arbiter with one output register stage.
// A source keeps the output from grant until its TLAST beat is accepted; each beat is tagged
// with its source index on m_axis_tdest.
// Optional feature: define AXIS_RR_ARB_PKT_CNT_EN to add per-source 16-bit packet counters
// on the pkt_cnt port.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
`ifdef AXIS_RR_ARB_PKT_CNT_EN
    output logic [NUM_SRC*PKT_CNT_W-1:0] pkt_cnt,
`endif
    axis_rr_arbiter_if.slave             bus
);
    localparam int unsigned DEST_W = $clog2(NUM_SRC);

    arb_state_t        state_q, state_d;
    logic [DEST_W-1:0] grant_q, grant_d;
    logic [DEST_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [DEST_W-1:0] pick_idx;
    logic              pick_any;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              src_ready;
    logic              accept;
    logic [NUM_SRC-1:0] s_ready;

    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [DEST_W-1:0] out_dest_q;

    axis_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req     (bus.s_axis_tvalid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Route the granted source's lane to the output register input.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == DEST_W'(i)) begin
                sel_data  = bus.s_axis_tdata[i*DATA_W +: DATA_W];
                sel_valid = bus.s_axis_tvalid[i];
                sel_last  = bus.s_axis_tlast[i];
            end
        end
    end

    // Ready only to the granted source, and only when the output register can take a beat.
    always_comb begin
        src_ready = (state_q == ST_BUSY) && (!out_valid_q || bus.m_axis_tready);
        accept    = src_ready && sel_valid;
        s_ready   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            s_ready[i] = src_ready && (grant_q == DEST_W'(i));
        end
    end

    // Next-state: arbitrate in idle, release the grant after the TLAST beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == DEST_W'(NUM_SRC - 1)) ? '0 : pick_idx + DEST_W'(1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output register: load on acceptance, drain on downstream ready, hold while stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_dest_q  <= '0;
        end else if (accept) begin
            out_data_q  <= sel_data;
            out_valid_q <= 1'b1;
            out_last_q  <= sel_last;
            out_dest_q  <= grant_q;
        end else if (bus.m_axis_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tdata  = out_data_q;
    assign bus.m_axis_tvalid = out_valid_q;
    assign bus.m_axis_tlast  = out_last_q;
    assign bus.m_axis_tdest  = out_dest_q;

`ifdef AXIS_RR_ARB_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] cnt_q [NUM_SRC];

    // Per-source completed-packet counters; wrap naturally at all-ones.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (accept && sel_last && (grant_q == DEST_W'(i))) begin
                    cnt_q[i] <= cnt_q[i] + PKT_CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counters onto the output port.
    always_comb begin
        pkt_cnt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed reset/latency and mid-packet reset cases,
// plus packet phases checked against a round-robin packet-order model.
module tb_axis_rr_arbiter;
    import axis_arb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    dest;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    axis_rr_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

`ifdef AXIS_RR_ARB_PKT_CNT_EN
    logic [NS*PKT_CNT_W-1:0] pkt_cnt;
`endif

    axis_rr_arbiter #(
        .NUM_SRC (NS),
        .DATA_W  (DW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
`ifdef AXIS_RR_ARB_PKT_CNT_EN
        .pkt_cnt (pkt_cnt),
`endif
        .bus     (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Per-source beat storage and progress.
    logic [DW-1:0] s_data_mem [NS][64];
    logic          s_last_mem [NS][64];
    int            s_len  [NS];
    int            s_pos  [NS];
    int            gap_cnt[NS];

    beat_t exp_q[$];
    int    in_order[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    // Present each source's current beat; first beats of a packet are always valid.
    task automatic drive_inputs(input int gap_mode);
        logic first;
        logic v;
        for (int s = 0; s < NS; s++) begin
            if (s_pos[s] < s_len[s]) begin
                first = 1'b1;
                if (s_pos[s] > 0) first = s_last_mem[s][s_pos[s]-1];
                bus.s_axis_tdata[s*DW +: DW] = s_data_mem[s][s_pos[s]];
                bus.s_axis_tlast[s] = s_last_mem[s][s_pos[s]];
                if (first) v = 1'b1;
                else if (gap_mode == 1) v = ($urandom_range(3) != 0);
                else if (gap_mode == 2 && gap_cnt[s] > 0) begin
                    v = 1'b0;
                    gap_cnt[s]--;
                end else v = 1'b1;
                bus.s_axis_tvalid[s] = v;
            end else begin
                bus.s_axis_tdata[s*DW +: DW] = '0;
                bus.s_axis_tlast[s]  = 1'b0;
                bus.s_axis_tvalid[s] = 1'b0;
            end
        end
    endtask

    task automatic drive_ready(input int rdy_mode, input int cyc);
        if (rdy_mode == 0) bus.m_axis_tready = 1'b1;
        else if (rdy_mode == 1) bus.m_axis_tready = ($urandom_range(3) != 0);
        else bus.m_axis_tready = ((cyc % 8) >= 2);
    endtask

    // npk: packets per source, one nibble per source. data_base=0 means random data.
    task automatic run_phase(input string name, input logic [15:0] npk, input int lmin,
                             input int lmax, input int gap_mode, input int rdy_mode,
                             input logic [31:0] data_base, input bit do_rst,
                             input int exp_span);
        int rem[NS];
        int rd[NS];
        int ptr;
        int pick;
        int len;
        int cyc;
        int first_out;
        int last_out;
        bit done;
        logic [NS-1:0] rdy;
        logic [NS-1:0] hs;
        logic lst;

        if (do_rst) apply_reset();
        exp_q.delete();
        in_order.delete();
        for (int s = 0; s < NS; s++) begin
            s_len[s] = 0;
            s_pos[s] = 0;
            gap_cnt[s] = 0;
            rd[s] = 0;
            rem[s] = int'(npk[s*4 +: 4]);
            for (int p = 0; p < rem[s]; p++) begin
                len = $urandom_range(lmax, lmin);
                for (int b = 0; b < len; b++) begin
                    s_data_mem[s][s_len[s]] = (data_base != 0) ? data_base + s_len[s] : $urandom;
                    s_last_mem[s][s_len[s]] = (b == len - 1);
                    s_len[s]++;
                end
            end
        end

        // Packet order: every source with packets left is requesting whenever the arbiter
        // is idle, so the order is plain round-robin over non-empty sources from pointer 0.
        ptr  = 0;
        done = 1'b0;
        while (!done) begin
            pick = -1;
            for (int k = 0; k < NS; k++) begin
                if (pick < 0 && rem[(ptr + k) % NS] > 0) pick = (ptr + k) % NS;
            end
            if (pick < 0) done = 1'b1;
            else begin
                do begin
                    lst = s_last_mem[pick][rd[pick]];
                    exp_q.push_back('{dest: 2'(pick), data: s_data_mem[pick][rd[pick]], last: lst});
                    rd[pick]++;
                end while (!lst);
                rem[pick]--;
                in_order.push_back(pick);
                ptr = (pick + 1) % NS;
            end
        end

        cyc = 0;
        first_out = -1;
        last_out = -1;
        drive_inputs(gap_mode);
        drive_ready(rdy_mode, cyc);
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge aclk);
            rdy = bus.s_axis_tready;
            if (rdy != '0) begin
                if (in_order.size() > 0) check_eq({name, "_grant"}, 64'(rdy), 64'(1 << in_order[0]));
                else check_eq({name, "_grant_idle"}, 64'(rdy), 64'(0));
            end
            hs = rdy & bus.s_axis_tvalid;
            for (int s = 0; s < NS; s++) begin
                if (hs[s]) begin
                    if (s_last_mem[s][s_pos[s]]) begin
                        if (in_order.size() > 0) void'(in_order.pop_front());
                    end else if (gap_mode == 2 && (s_pos[s] == 0 || s_last_mem[s][s_pos[s]-1])) begin
                        gap_cnt[s] = 5;
                    end
                    s_pos[s]++;
                end
            end
            if (bus.m_axis_tvalid) begin
                if (exp_q.size() == 0) check_eq({name, "_extra_beat"}, 64'(1), 64'(0));
                else begin
                    check_eq({name, "_dest"}, 64'(bus.m_axis_tdest), 64'(exp_q[0].dest));
                    check_eq({name, "_data"}, 64'(bus.m_axis_tdata), 64'(exp_q[0].data));
                    check_eq({name, "_last"}, 64'(bus.m_axis_tlast), 64'(exp_q[0].last));
                    if (bus.m_axis_tready) begin
                        void'(exp_q.pop_front());
                        if (first_out < 0) first_out = cyc;
                        last_out = cyc;
                    end
                end
            end
            cyc++;
            @(posedge aclk);
            #1;
            drive_inputs(gap_mode);
            drive_ready(rdy_mode, cyc);
        end
        check_eq({name, "_beats_left"}, 64'(exp_q.size()), 64'(0));
        if (exp_span >= 0) check_eq({name, "_span"}, 64'(last_out - first_out), 64'(exp_span));
        bus.s_axis_tvalid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds everything quiet even with all sources requesting.
        aresetn = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.s_axis_tvalid = '1;
        bus.s_axis_tlast  = '1;
        for (int s = 0; s < NS; s++) bus.s_axis_tdata[s*DW +: DW] = 32'h100 + 32'(s);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_s_tready", 64'(bus.s_axis_tready), 64'(0));
        check_eq("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
        check_eq("rst_m_tdata",  64'(bus.m_axis_tdata),  64'(0));
        check_eq("rst_m_tlast",  64'(bus.m_axis_tlast),  64'(0));
        check_eq("rst_m_tdest",  64'(bus.m_axis_tdest),  64'(0));

        // First-beat latency out of reset: ready in cycle 1, output valid in cycle 2.
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check_eq("lat_c0_ready", 64'(bus.s_axis_tready), 64'(0));
        @(negedge aclk);
        check_eq("lat_c1_ready", 64'(bus.s_axis_tready), 64'(4'b0001));
        check_eq("lat_c1_valid", 64'(bus.m_axis_tvalid), 64'(0));
        @(posedge aclk);
        #1 bus.s_axis_tvalid[0] = 1'b0;
        @(negedge aclk);
        check_eq("lat_c2_valid", 64'(bus.m_axis_tvalid), 64'(1));
        check_eq("lat_c2_dest",  64'(bus.m_axis_tdest),  64'(0));
        check_eq("lat_c2_data",  64'(bus.m_axis_tdata),  64'(32'h100));
        check_eq("lat_c2_ready", 64'(bus.s_axis_tready), 64'(0));
        @(negedge aclk);
        check_eq("lat_c3_ready", 64'(bus.s_axis_tready), 64'(4'b0010));

        // Continuous 3-beat packets: 12 packets, one idle bubble between packets.
        run_phase("fair", 16'h3333, 3, 3, 0, 0, 32'h0, 1'b1, 46);
        // Source 2 alone under a 2-low/6-high ready pattern.
        run_phase("bp", 16'h0100, 8, 8, 0, 2, 32'hA0, 1'b1, -1);
        // Source 1 stalls 5 cycles after its first beat while source 3 waits.
        run_phase("lock", 16'h1010, 4, 4, 2, 0, 32'h0, 1'b1, -1);

        // Mid-packet reset from source 1, which also moves the pointer away from 0.
        apply_reset();
        bus.m_axis_tready = 1'b1;
        bus.s_axis_tvalid = 4'b0010;
        bus.s_axis_tdata[1*DW +: DW] = 32'h11;
        repeat (2) @(posedge aclk);
        #1 bus.s_axis_tdata[1*DW +: DW] = 32'h12;
        @(posedge aclk);
        #1 bus.s_axis_tdata[1*DW +: DW] = 32'h13;
        #1 check_eq("midrst_pre_valid", 64'(bus.m_axis_tvalid), 64'(1));
        #1 aresetn = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(bus.m_axis_tvalid), 64'(0));
        check_eq("midrst_ready", 64'(bus.s_axis_tready), 64'(0));
        check_eq("midrst_data",  64'(bus.m_axis_tdata),  64'(0));
        bus.s_axis_tvalid = '0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        run_phase("post_rst", 16'h1111, 1, 4, 0, 0, 32'h0, 1'b0, -1);

        // Randomized mixes of packet counts, lengths, valid gaps and backpressure.
        for (int r = 0; r < 6; r++) begin
            run_phase("rand", 16'($urandom_range(16'hFFFF)) & 16'h3333, 1, 6, 1, 1, 32'h0,
                      1'b1, -1);
        end

`ifdef AXIS_RR_ARB_PKT_CNT_EN
        run_phase("cnt", 16'h2005, 1, 3, 0, 1, 32'h0, 1'b1, -1);
        repeat (3) @(posedge aclk);
        #1;
        check_eq("cnt_src0", 64'(pkt_cnt[0*PKT_CNT_W +: PKT_CNT_W]), 64'(5));
        check_eq("cnt_src1", 64'(pkt_cnt[1*PKT_CNT_W +: PKT_CNT_W]), 64'(0));
        check_eq("cnt_src2", 64'(pkt_cnt[2*PKT_CNT_W +: PKT_CNT_W]), 64'(0));
        check_eq("cnt_src3", 64'(pkt_cnt[3*PKT_CNT_W +: PKT_CNT_W]), 64'(2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin N:1 AXI4-Stream packet arbiter that shares one downstream AXI4-Stream slave between several upstream masters. Grants are packet-granular: once a source wins, it keeps the output until its TLAST beat has been accepted. The block sits between the master-side stream sources and a single consumer, such as the slave VIP or a DMA. It adds one output register stage and tags each beat with the index of its source.

## Interface
- NUM_SRC, 4: number of upstream sources, ≥2
- DATA_W, 32: TDATA width in bits, multiple of 8
- DEST_W, $clog2(NUM_SRC): width of m_axis_tdest (derived; do not override)

Ports:
- aclk  in  1  single clock; all logic is on its rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  NUM_SRC*DATA_W  source data, source i occupies bits [i*DATA_W +: DATA_W]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source end of packet
- s_axis_tready  out  NUM_SRC  per-source ready
- m_axis_tdata  out  DATA_W  registered output data
- m_axis_tvalid  out  1  registered output valid
- m_axis_tlast  out  1  registered output last
- m_axis_tdest  out  DEST_W  index of the source that produced the current beat
- m_axis_tready  in  1  downstream ready

## Operation
- FSM states (declared in package): ST_IDLE, ST_BUSY.
- ST_IDLE behaviour:
  - All s_axis_tready are 0.
  - If any s_axis_tvalid is 1, select the first requester at or after rr_ptr, scanning upward modulo NUM_SRC.
  - On the edge: register it as grant, set rr_ptr = (grant+1) mod NUM_SRC, go to ST_BUSY.
- ST_BUSY behaviour:
  - s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready. All other readies are 0.
  - A beat is accepted when s_axis_tvalid[grant] && s_axis_tready[grant]. On acceptance, load tdata, tlast and tdest=grant into the output register and set m_axis_tvalid=1.
  - If the accepted beat has tlast=1, go to ST_IDLE on the same edge.
- Output register:
  - m_axis_tvalid clears when m_axis_tready=1 and no new beat is loaded in that cycle.
  - Output contents hold stable while m_axis_tvalid=1 && m_axis_tready=0.
- rr_ptr reset value is 0.
- Source valid dropping mid-packet: the grant is held and the block waits; it never switches sources before TLAST.
- A non-granted source holding tvalid is never dropped. It stalls until its turn; worst-case wait is (NUM_SRC-1) packets.
- Single-beat packet (tvalid and tlast together): accepted in one ST_BUSY cycle, then return to ST_IDLE.
- Mid-packet reset:
  - Asynchronous clear of FSM, grant, rr_ptr and output register.
  - Any partial packet is discarded. The downstream sees no TLAST for it; this is accepted behaviour.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tdest=0.
- First-beat latency with an idle arbiter:
  - s_axis_tvalid rises in cycle 0.
  - s_axis_tready rises in cycle 1.
  - m_axis_tvalid rises in cycle 2.
- Steady state: one beat per cycle while m_axis_tready=1.
- Between packets: exactly one ST_IDLE cycle on the input side. The output register still drains during that cycle.
- s_axis_tready depends combinationally on m_axis_tready; the only comb path is m_axis_tready→s_axis_tready.
- Simultaneous output drain and input load in the same cycle: the output register takes the new beat and m_axis_tvalid stays 1.

## Configuration
- AXIS_RR_ARB_PKT_CNT_EN defined:
  - Adds output port pkt_cnt (NUM_SRC*16), one 16-bit counter per source.
  - A counter increments when its source's TLAST beat is accepted, wraps 0xFFFF→0, and resets to 0.
- AXIS_RR_ARB_PKT_CNT_EN undefined: the port and counters are absent; no other behaviour changes.

## Structure
- Package axis_arb_pkg contains:
  - state enum arb_state_t {ST_IDLE, ST_BUSY}
  - PKT_CNT_W=16 constant
- Sub-module axis_rr_pick: purely combinational round-robin picker (req[NUM_SRC], ptr → gnt_idx, gnt_any), instantiated once.
- All sequencing and the output register live in axis_rr_arbiter.

## Test plan
- Reset and idle:
  - Stimulus: hold aresetn=0 with all s_axis_tvalid=1.
  - Required: all s_axis_tready=0 and m_axis_tvalid=0; after release, first grant goes to source 0 (tdest=0).
- Round-robin fairness:
  - Stimulus: 4 sources each present 3-beat packets continuously with m_axis_tready=1.
  - Required: tdest sequence 0,1,2,3,0,…; output data is per-source contiguous; 3 beats out per 4 cycles.
- Backpressure:
  - Stimulus: source 2 sends data 0xA0..0xA7 (8 beats) while m_axis_tready toggles low 2 / high 6 cycles.
  - Required: no beat lost or duplicated; output stable while stalled; tlast only on 0xA7.
- Packet lock:
  - Stimulus: source 1 is mid-packet and drops tvalid for 5 cycles while source 3 requests.
  - Required: source 3 gets no tready until source 1's TLAST beat is accepted.
- Mid-packet reset:
  - Stimulus: assert aresetn low during beat 2 of a 4-beat packet.
  - Required: m_axis_tvalid=0 immediately (asynchronous); after release, rr_ptr=0 and a new packet passes intact.
- Counters (with AXIS_RR_ARB_PKT_CNT_EN):
  - Stimulus: 5 packets from source 0 and 2 packets from source 3.
  - Required: pkt_cnt[0]=5, pkt_cnt[3]=2, others 0.
